// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder: encodes symbolic commands into MIPS words written to sequential imem addresses
module mips_instr_encoder #(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [3:0]            cmd_kind,
  input  logic [4:0]            cmd_rs,
  input  logic [4:0]            cmd_rt,
  input  logic [4:0]            cmd_rd,
  input  logic [15:0]           cmd_imm,
  input  logic [25:0]           cmd_target,
  input  logic                  cmd_last,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic                  err_illegal
);
  // Capacity counted from BASE_ADDR; the pointer is derived from count so it cannot wrap
  localparam logic [ADDR_WIDTH:0] CAP = (ADDR_WIDTH+1)'((2 ** ADDR_WIDTH) - BASE_ADDR);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;
  state_t                r_state;
  logic                  r_we, r_done, r_ovf, r_err;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  w_full, w_next_full, w_hs, w_legal;
  logic [5:0]            w_funct, w_iop;
  logic [31:0]           w_enc;
  logic [ADDR_WIDTH-1:0] w_addr;
  assign w_full      = r_count == CAP;
  assign w_next_full = (r_count + 1'b1) == CAP;
  assign cmd_ready   = (r_state == S_LOAD) && !w_full;
  assign w_hs        = cmd_valid && cmd_ready;
  assign w_legal     = cmd_kind <= 4'd9;
  assign w_addr      = ADDR_WIDTH'(BASE_ADDR) + r_count[ADDR_WIDTH-1:0];
  assign imem_we     = r_we;
  assign imem_addr   = r_addr;
  assign imem_wdata  = r_wdata;
  assign count       = r_count;
  assign busy        = r_state == S_LOAD;
  assign done        = r_done;
  assign overflow    = r_ovf;
  assign err_illegal = r_err;
  // Instruction encoding: R-type funct, I-type opcode, J-type
  always_comb begin
    w_funct = cmd_kind == 4'd0 ? 6'h20 : cmd_kind == 4'd1 ? 6'h22 :
              cmd_kind == 4'd2 ? 6'h24 : cmd_kind == 4'd3 ? 6'h25 : 6'h2A;
    w_iop   = cmd_kind == 4'd5 ? 6'h23 : cmd_kind == 4'd6 ? 6'h2B :
              cmd_kind == 4'd7 ? 6'h04 : 6'h08;
    w_enc   = cmd_kind < 4'd5 ? {6'b000000, cmd_rs, cmd_rt, cmd_rd, 5'b0, w_funct} :
              cmd_kind == 4'd9 ? {6'b000010, cmd_target} :
              {w_iop, cmd_rs, cmd_rt, cmd_imm};
  end
  // Control FSM with registered write port and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_count <= '0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      if (start) begin
        r_state <= S_LOAD;
        r_count <= '0;
        r_ovf   <= 1'b0;
        r_err   <= 1'b0;
      end else if (r_state == S_DONE) begin
        r_state <= S_IDLE;
        r_done  <= 1'b1;
      end else if (w_hs) begin
        if (w_legal) begin
          r_we    <= 1'b1;
          r_addr  <= w_addr;
          r_wdata <= w_enc;
          r_count <= r_count + 1'b1;
        end else begin
          r_err <= 1'b1;
        end
        if (cmd_last) begin
          r_state <= S_DONE;
        end else if (w_legal && w_next_full) begin
          r_state <= S_DONE;
          r_ovf   <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mips_instr_encoder.sv
// tb_mips_instr_encoder: directed checks of encoding, addressing, flags and handshake
module tb_mips_instr_encoder;
  logic        clk = 1'b0;
  logic        rst_n, start, cmd_valid, cmd_last;
  logic [3:0]  cmd_kind;
  logic [4:0]  cmd_rs, cmd_rt, cmd_rd;
  logic [15:0] cmd_imm;
  logic [25:0] cmd_target;
  logic        a_ready, a_we, a_busy, a_done, a_ovf, a_err;
  logic [7:0]  a_addr;
  logic [31:0] a_wdata;
  logic [8:0]  a_count;
  logic        b_ready, b_we, b_busy, b_done, b_ovf, b_err;
  logic [1:0]  b_addr;
  logic [31:0] b_wdata;
  logic [2:0]  b_count;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mips_instr_encoder #(.ADDR_WIDTH(8), .BASE_ADDR(0)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd_valid(cmd_valid), .cmd_ready(a_ready),
    .cmd_kind(cmd_kind), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd), .cmd_imm(cmd_imm),
    .cmd_target(cmd_target), .cmd_last(cmd_last), .imem_we(a_we), .imem_addr(a_addr),
    .imem_wdata(a_wdata), .count(a_count), .busy(a_busy), .done(a_done), .overflow(a_ovf),
    .err_illegal(a_err));

  mips_instr_encoder #(.ADDR_WIDTH(2), .BASE_ADDR(0)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd_valid(cmd_valid), .cmd_ready(b_ready),
    .cmd_kind(cmd_kind), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd), .cmd_imm(cmd_imm),
    .cmd_target(cmd_target), .cmd_last(cmd_last), .imem_we(b_we), .imem_addr(b_addr),
    .imem_wdata(b_wdata), .count(b_count), .busy(b_busy), .done(b_done), .overflow(b_ovf),
    .err_illegal(b_err));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drive(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                       input logic last);
    cmd_kind = k; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd;
    cmd_imm = imm; cmd_target = tgt; cmd_last = last; cmd_valid = 1'b1;
  endtask

  task automatic send(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                      input logic last);
    drive(k, rs, rt, rd, imm, tgt, last);
    chk("ready_before_send", {31'b0, a_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
    cmd_last  = 1'b0;
  endtask

  task automatic chk_wr(input string tag, input logic [7:0] addr, input logic [31:0] data,
                        input logic [8:0] cnt);
    chk({tag, "_we"}, {31'b0, a_we}, 32'd1);
    chk({tag, "_addr"}, {24'b0, a_addr}, {24'b0, addr});
    chk({tag, "_data"}, a_wdata, data);
    chk({tag, "_count"}, {23'b0, a_count}, {23'b0, cnt});
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; cmd_valid = 1'b0; cmd_last = 1'b0;
    cmd_kind = '0; cmd_rs = '0; cmd_rt = '0; cmd_rd = '0; cmd_imm = '0; cmd_target = '0;
    #12;
    chk("rst_we", {31'b0, a_we}, 32'd0);
    chk("rst_ready", {31'b0, a_ready}, 32'd0);
    chk("rst_busy", {31'b0, a_busy}, 32'd0);
    chk("rst_done", {31'b0, a_done}, 32'd0);
    chk("rst_flags", {30'b0, a_ovf, a_err}, 32'd0);
    chk("rst_count", {23'b0, a_count}, 32'd0);
    chk("rst_wdata", a_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    // ADD with cmd_last
    pulse_start();
    chk("busy_after_start", {31'b0, a_busy}, 32'd1);
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b1);
    chk_wr("add", 8'd0, 32'h0022_1820, 9'd1);
    chk("add_busy_off", {31'b0, a_busy}, 32'd0);
    tick();
    chk("add_done", {31'b0, a_done}, 32'd1);
    chk("add_we_off", {31'b0, a_we}, 32'd0);
    tick();
    chk("add_done_off", {31'b0, a_done}, 32'd0);
    // LW then BEQ
    pulse_start();
    send(4'd5, 5'd29, 5'd8, 5'd0, 16'd4, 26'd0, 1'b0);
    chk_wr("lw", 8'd0, 32'h8FA8_0004, 9'd1);
    send(4'd7, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'd0, 1'b1);
    chk_wr("beq", 8'd1, 32'h1022_FFFF, 9'd2);
    tick();
    chk("beq_done", {31'b0, a_done}, 32'd1);
    // ADDI then J, done exactly one cycle
    pulse_start();
    send(4'd8, 5'd0, 5'd1, 5'd0, 16'd5, 26'd0, 1'b0);
    chk_wr("addi", 8'd0, 32'h2001_0005, 9'd1);
    send(4'd9, 5'd0, 5'd0, 5'd0, 16'd0, 26'h10, 1'b1);
    chk_wr("j", 8'd1, 32'h0800_0010, 9'd2);
    chk("j_done_early", {31'b0, a_done}, 32'd0);
    tick();
    chk("j_done", {31'b0, a_done}, 32'd1);
    tick();
    chk("j_done_once", {31'b0, a_done}, 32'd0);
    // illegal kind between two ADDs
    pulse_start();
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0);
    chk_wr("ill_add0", 8'd0, 32'h0022_1820, 9'd1);
    send(4'd12, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0);
    chk("ill_no_we", {31'b0, a_we}, 32'd0);
    chk("ill_err", {31'b0, a_err}, 32'd1);
    chk("ill_count", {23'b0, a_count}, 32'd1);
    send(4'd0, 5'd1, 5'd2, 5'd4, 16'd0, 26'd0, 1'b1);
    chk_wr("ill_add1", 8'd1, 32'h0022_2020, 9'd2);
    chk("ill_err_sticky", {31'b0, a_err}, 32'd1);
    tick();
    tick();
    // overflow on the 4-word instance
    pulse_start();
    chk("err_cleared", {31'b0, a_err}, 32'd0);
    for (int i = 0; i < 4; i++) send(4'd3, 5'd1, 5'd2, 5'(i), 16'd0, 26'd0, 1'b0);
    chk("ovf_we", {31'b0, b_we}, 32'd1);
    chk("ovf_addr", {30'b0, b_addr}, 32'd3);
    chk("ovf_data", b_wdata, 32'h0022_1825);
    chk("ovf_count", {29'b0, b_count}, 32'd4);
    chk("ovf_ready", {31'b0, b_ready}, 32'd0);
    chk("ovf_flag", {31'b0, b_ovf}, 32'd1);
    chk("ovf_a_clean", {31'b0, a_ovf}, 32'd0);
    drive(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0);
    tick();
    chk("ovf_done", {31'b0, b_done}, 32'd1);
    chk("ovf_5th_no_we", {31'b0, b_we}, 32'd0);
    tick();
    cmd_valid = 1'b0;
    chk("ovf_5th_still_no_we", {31'b0, b_we}, 32'd0);
    chk("ovf_count_held", {29'b0, b_count}, 32'd4);
    // start in LOAD aborts and restarts at base
    pulse_start();
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0);
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0);
    chk("abort_pre_count", {23'b0, a_count}, 32'd2);
    pulse_start();
    chk("abort_count", {23'b0, a_count}, 32'd0);
    chk("abort_busy", {31'b0, a_busy}, 32'd1);
    chk("abort_ovf_clr", {31'b0, b_ovf}, 32'd0);
    send(4'd1, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b1);
    chk_wr("abort_sub", 8'd0, 32'h0022_1822, 9'd1);
    tick();
    tick();
    // async reset mid-program, then restart with cmd_valid already high
    pulse_start();
    send(4'd2, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0);
    send(4'd2, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_we", {31'b0, a_we}, 32'd0);
    chk("arst_count", {23'b0, a_count}, 32'd0);
    chk("arst_busy", {31'b0, a_busy}, 32'd0);
    chk("arst_addr", {24'b0, a_addr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    drive(4'd4, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b1);
    pulse_start();
    chk("start_valid_not_taken", {23'b0, a_count}, 32'd0);
    chk("start_valid_no_we", {31'b0, a_we}, 32'd0);
    send(4'd4, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b1);
    chk_wr("post_rst_slt", 8'd0, 32'h0022_182A, 9'd1);
    tick();
    chk("post_rst_done", {31'b0, a_done}, 32'd1);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
